// File: rtl/local_history_predictor.sv
// Two-level local-history direction predictor with self-initialising sweep.
// Define LHP_PC_HASH_EN to XOR PC bits into the PHT index (PAs), else pure PAg.
module local_history_predictor #(
    parameter int FETCH_WIDTH = 2,
    parameter int UPD_PORTS   = 2,
    parameter int ADDR_W      = 32,
    parameter int BHT_ENTRIES = 256,
    parameter int HIST_BITS   = 8,
    parameter int CTR_BITS    = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             stall,
    input  logic                             flush,
    input  logic                             fetchValid,
    input  logic [ADDR_W-1:0]                fetchPC,
    input  logic [FETCH_WIDTH-1:0]           btbHit,
    input  logic [FETCH_WIDTH-1:0]           isCondBr,
    output logic                             ready,
    output logic [FETCH_WIDTH-1:0]           predTaken,
    output logic [FETCH_WIDTH*HIST_BITS-1:0] predHist,
    output logic [FETCH_WIDTH*CTR_BITS-1:0]  predCtr,
    input  logic [UPD_PORTS-1:0]             updValid,
    input  logic [UPD_PORTS*ADDR_W-1:0]      updPC,
    input  logic [UPD_PORTS*HIST_BITS-1:0]   updHist,
    input  logic [UPD_PORTS-1:0]             updTaken,
    input  logic [UPD_PORTS-1:0]             updMispred,
    input  logic [UPD_PORTS-1:0]             updIsCond
);

    localparam int IDX_W       = $clog2(BHT_ENTRIES);
    localparam int PHT_ENTRIES = 1 << HIST_BITS;
    localparam int SWEEP       = (BHT_ENTRIES > PHT_ENTRIES) ? BHT_ENTRIES : PHT_ENTRIES;
    localparam int SW_W        = $clog2(SWEEP);
    localparam int PC_W        = (IDX_W > HIST_BITS) ? IDX_W : HIST_BITS;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
`ifdef LHP_PC_HASH_EN
    localparam bit HASH = 1'b1;
`else
    localparam bit HASH = 1'b0;
`endif

    typedef enum logic {INIT, RUN} state_t;

    state_t            stateQ, stateD;
    logic [SW_W-1:0]   sweepIdx;
    logic [HIST_BITS-1:0] bht [BHT_ENTRIES];
    logic [CTR_BITS-1:0]  pht [PHT_ENTRIES];

    logic [PC_W-1:0]      lanePc   [FETCH_WIDTH];
    logic [IDX_W-1:0]     laneIdx  [FETCH_WIDTH];
    logic [HIST_BITS-1:0] laneHist [FETCH_WIDTH];
    logic [HIST_BITS-1:0] laneNext [FETCH_WIDTH];
    logic [CTR_BITS-1:0]  laneCtr  [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] laneTaken, laneWr;
    logic                   blocked;

    logic [PC_W-1:0]      updPcb   [UPD_PORTS];
    logic [HIST_BITS-1:0] updH     [UPD_PORTS];
    logic [HIST_BITS-1:0] updPht   [UPD_PORTS];
    logic [CTR_BITS-1:0]  updCtr   [UPD_PORTS];
    logic [HIST_BITS-1:0] recHist  [UPD_PORTS];
    logic [UPD_PORTS-1:0] updEn, recEn;
    logic [CTR_BITS-1:0]  cur;
    logic                 unusedBits;

    logic running, specEn;
    assign running = (stateQ == RUN);
    assign ready   = running;
    assign specEn  = running & ~stall & ~flush;

    always_comb begin
        stateD = stateQ;
        if (stateQ == INIT && sweepIdx == SW_W'(SWEEP - 1))
            stateD = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= INIT;
            sweepIdx <= '0;
        end else begin
            stateQ <= stateD;
            if (stateQ == INIT)
                sweepIdx <= sweepIdx + 1'b1;
        end
    end

    // Lanes walk in order; an aliasing later lane sees the earlier lane's shifted history.
    always_comb begin
        blocked   = 1'b0;
        laneTaken = '0;
        laneWr    = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lanePc[i]   = '0;
            laneIdx[i]  = '0;
            laneHist[i] = '0;
            laneNext[i] = '0;
            laneCtr[i]  = '0;
        end
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lanePc[i]   = fetchPC[PC_W+1:2] + PC_W'(i);
            laneIdx[i]  = lanePc[i][IDX_W-1:0];
            laneHist[i] = bht[laneIdx[i]];
            for (int k = 0; k < FETCH_WIDTH; k++)
                if (k < i && laneWr[k] && laneIdx[k] == laneIdx[i])
                    laneHist[i] = laneNext[k];
            laneCtr[i] = pht[laneHist[i] ^
                (HASH ? lanePc[i][HIST_BITS-1:0] : {HIST_BITS{1'b0}})];
            laneTaken[i] = laneCtr[i][CTR_BITS-1] & btbHit[i] & fetchValid & ~blocked;
            laneWr[i]    = fetchValid & btbHit[i] & isCondBr[i] & ~blocked;
            laneNext[i]  = {laneHist[i][HIST_BITS-2:0], laneTaken[i]};
            blocked      = blocked | laneTaken[i];
        end
    end

    // Same-counter updates chain so the stored value is the net effect in port order.
    always_comb begin
        updEn = '0;
        recEn = '0;
        cur   = '0;
        unusedBits = ^fetchPC[1:0] ^ ^fetchPC[ADDR_W-1:PC_W+2];
        for (int j = 0; j < UPD_PORTS; j++) begin
            updPcb[j]  = '0;
            updH[j]    = '0;
            updPht[j]  = '0;
            updCtr[j]  = '0;
            recHist[j] = '0;
        end
        for (int j = 0; j < UPD_PORTS; j++) begin
            unusedBits = unusedBits ^ ^updPC[j*ADDR_W +: 2]
                       ^ ^updPC[j*ADDR_W+PC_W+2 +: ADDR_W-PC_W-2];
            updPcb[j]  = updPC[j*ADDR_W+2 +: PC_W];
            updH[j]    = updHist[j*HIST_BITS +: HIST_BITS];
            updPht[j]  = updH[j] ^ (HASH ? updPcb[j][HIST_BITS-1:0] : {HIST_BITS{1'b0}});
            updEn[j]   = running & updValid[j] & updIsCond[j];
            recEn[j]   = updEn[j] & updMispred[j];
            recHist[j] = {updH[j][HIST_BITS-2:0], updTaken[j]};
            cur = pht[updPht[j]];
            for (int k = 0; k < UPD_PORTS; k++)
                if (k < j && updEn[k] && updPht[k] == updPht[j])
                    cur = updCtr[k];
            if (updTaken[j])
                updCtr[j] = (cur == CTR_MAX) ? cur : cur + 1'b1;
            else
                updCtr[j] = (cur == '0) ? cur : cur - 1'b1;
        end
    end

    // Tables carry no reset; the INIT sweep establishes their contents.
    always_ff @(posedge clk) begin
        if (stateQ == INIT) begin
            if (int'(sweepIdx) < BHT_ENTRIES)
                bht[sweepIdx[IDX_W-1:0]] <= '0;
            if (int'(sweepIdx) < PHT_ENTRIES)
                pht[sweepIdx[HIST_BITS-1:0]] <= CTR_WEAK;
        end else begin
            for (int j = 0; j < UPD_PORTS; j++)
                if (updEn[j])
                    pht[updPht[j]] <= updCtr[j];
            if (specEn)
                for (int i = 0; i < FETCH_WIDTH; i++)
                    if (laneWr[i])
                        bht[laneIdx[i]] <= laneNext[i];
            for (int j = UPD_PORTS - 1; j >= 0; j--)
                if (recEn[j])
                    bht[updPcb[j][IDX_W-1:0]] <= recHist[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            predTaken <= '0;
            predHist  <= '0;
            predCtr   <= '0;
        end else if (!running) begin
            predTaken <= '0;
            predHist  <= '0;
            predCtr   <= '0;
        end else if (!stall) begin
            predTaken <= laneTaken;
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                predHist[i*HIST_BITS +: HIST_BITS] <= laneHist[i];
                predCtr[i*CTR_BITS +: CTR_BITS]    <= laneCtr[i];
            end
        end
    end

endmodule

// File: tb/tb_local_history_predictor.sv
// Scoreboard bench for local_history_predictor: a behavioural table model
// queues expected predictions as stimulus is driven, compared one cycle later.
module tb_local_history_predictor;

    localparam int FW = 2;
    localparam int UP = 2;
    localparam int AW = 32;
    localparam int HB = 8;
    localparam int CB = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic stall, flush, fetchValid;
    logic [AW-1:0] fetchPC;
    logic [FW-1:0] btbHit, isCondBr;
    logic ready;
    logic [FW-1:0] predTaken;
    logic [FW*HB-1:0] predHist;
    logic [FW*CB-1:0] predCtr;
    logic [UP-1:0] updValid, updTaken, updMispred, updIsCond;
    logic [UP*AW-1:0] updPC;
    logic [UP*HB-1:0] updHist;

    local_history_predictor dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .fetchValid(fetchValid), .fetchPC(fetchPC), .btbHit(btbHit),
        .isCondBr(isCondBr), .ready(ready), .predTaken(predTaken),
        .predHist(predHist), .predCtr(predCtr), .updValid(updValid),
        .updPC(updPC), .updHist(updHist), .updTaken(updTaken),
        .updMispred(updMispred), .updIsCond(updIsCond)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [FW-1:0]    taken;
        logic [FW*HB-1:0] hist;
        logic [FW*CB-1:0] ctr;
    } exp_t;

    exp_t sbq[$];
    exp_t lastExp;
    int   mBht[256];
    int   mPht[256];
    int   nChecks = 0;
    int   nPass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic int pidx(input int h, input logic [31:0] pc);
`ifdef LHP_PC_HASH_EN
        return (h ^ int'(pc[9:2])) & 255;
`else
        return h & 255;
`endif
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 256; i++) begin
            mBht[i] = 0;
            mPht[i] = 2;
        end
        lastExp = '0;
    endtask

    task automatic idle();
        stall = 0; flush = 0; fetchValid = 0; fetchPC = '0;
        btbHit = '0; isCondBr = '0;
        updValid = '0; updPC = '0; updHist = '0;
        updTaken = '0; updMispred = '0; updIsCond = '0;
    endtask

    // Model one cycle: predictions from pre-edge state, then apply table writes.
    task automatic step();
        int   work[256];
        exp_t e;
        bit   blk;
        work = mBht;
        e    = '0;
        blk  = 0;
        for (int i = 0; i < FW; i++) begin
            logic [31:0] pc;
            int ix, h, c;
            bit t;
            pc = fetchPC + 32'(4 * i);
            ix = int'(pc[9:2]);
            h  = work[ix];
            c  = mPht[pidx(h, pc)];
            t  = (c >= 2) && btbHit[i] && fetchValid && !blk;
            e.hist[i*HB +: HB] = HB'(h);
            e.ctr[i*CB +: CB]  = CB'(c);
            e.taken[i]         = t;
            if (fetchValid && btbHit[i] && isCondBr[i] && !blk)
                work[ix] = ((h << 1) | int'(t)) & 255;
            if (t) blk = 1;
        end
        if (stall) e = lastExp;
        sbq.push_back(e);
        lastExp = e;
        for (int j = 0; j < UP; j++) begin
            if (updValid[j] && updIsCond[j]) begin
                int p;
                p = pidx(int'(updHist[j*HB +: HB]), updPC[j*AW +: AW]);
                if (updTaken[j]) begin
                    if (mPht[p] < 3) mPht[p]++;
                end else if (mPht[p] > 0) mPht[p]--;
            end
        end
        if (!stall && !flush) mBht = work;
        for (int j = UP - 1; j >= 0; j--) begin
            if (updValid[j] && updIsCond[j] && updMispred[j]) begin
                logic [31:0] upc;
                upc = updPC[j*AW +: AW];
                mBht[int'(upc[9:2])] =
                    ((int'(updHist[j*HB +: HB]) << 1) | int'(updTaken[j])) & 255;
            end
        end
    endtask

    task automatic cyc();
        exp_t e;
        step();
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check("sbEmpty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            check("predTaken", 32'(predTaken), 32'(e.taken));
            check("predHist", 32'(predHist), 32'(e.hist));
            check("predCtr", 32'(predCtr), 32'(e.ctr));
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [1:0] hit, input logic [1:0] cond);
        fetchValid = 1; fetchPC = pc; btbHit = hit; isCondBr = cond;
        cyc();
        idle();
    endtask

    task automatic sweepCheck(input string tag);
        repeat (255) @(posedge clk);
        #1;
        check({tag, "ReadyLow"}, 32'(ready), 32'd0);
        check({tag, "InitTaken"}, 32'(predTaken), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "ReadyHigh"}, 32'(ready), 32'd1);
        idle();
    endtask

    initial begin
        idle();
        modelReset();
        rst_n = 0;
        #3;
        check("rstReady", 32'(ready), 32'd0);
        check("rstOut", 32'({predTaken, predHist, predCtr}), 32'd0);
        #20 rst_n = 1;
        // Activity during the sweep must be ignored.
        fetchValid = 1; fetchPC = 32'h200; btbHit = 2'b11; isCondBr = 2'b11;
        updValid = 2'b01; updIsCond = 2'b01; updTaken = 2'b01; updMispred = 2'b01;
        updPC = {32'h0, 32'h200};
        sweepCheck("init");

        fetch(32'h200, 2'b01, 2'b00);
        check("firstCtr", 32'(predCtr[1:0]), 32'd2);
        check("firstTaken", 32'(predTaken), 32'd1);

        for (int n = 0; n < 4; n++) begin
            fetch(32'h100, 2'b01, 2'b01);
            check("chainTaken", 32'(predTaken[0]), 32'd1);
        end
        fetch(32'h100, 2'b01, 2'b00);
        check("hist0F", 32'(predHist[7:0]), 32'h0F);

        fetch(32'h300, 2'b11, 2'b11);
        check("blockedLane", 32'(predTaken[1]), 32'd0);
        fetch(32'h300, 2'b11, 2'b00);
        check("lane1Unchanged", 32'(predHist[15:8]), 32'h00);
        check("lane0Shifted", 32'(predHist[7:0]), 32'h01);

        updValid = 2'b11; updIsCond = 2'b11; updTaken = 2'b00;
        updPC = {32'h400, 32'h400}; updHist = '0;
        cyc();
        idle();
        fetch(32'h400, 2'b01, 2'b00);
        check("dualDec", 32'(predCtr[1:0]), 32'd0);

        fetchValid = 1; fetchPC = 32'h580; btbHit = 2'b01; isCondBr = 2'b01;
        updValid = 2'b01; updIsCond = 2'b01; updMispred = 2'b01; updTaken = 2'b00;
        updPC = {32'h0, 32'h580}; updHist = {8'h00, 8'h05};
        cyc();
        idle();
        fetch(32'h580, 2'b01, 2'b00);
        check("recoverWins", 32'(predHist[7:0]), 32'h0A);

        stall = 1;
        fetch(32'h100, 2'b11, 2'b11);
        flush = 1;
        fetch(32'h600, 2'b01, 2'b01);
        fetch(32'h600, 2'b01, 2'b00);
        check("flushNoWrite", 32'(predHist[7:0]), 32'h00);

        for (int n = 0; n < 300; n++) begin
            stall      = ($urandom_range(0, 9) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            fetchValid = ($urandom_range(0, 3) != 0);
            fetchPC    = 32'($urandom_range(0, 63)) << 2;
            btbHit     = 2'($urandom);
            isCondBr   = 2'($urandom);
            updValid   = 2'($urandom);
            updIsCond  = 2'($urandom) | 2'($urandom);
            updTaken   = 2'($urandom);
            updMispred = 2'($urandom);
            updPC      = {32'($urandom_range(0, 63)) << 2, 32'($urandom_range(0, 63)) << 2};
            updHist    = {8'($urandom_range(0, 7)), 8'($urandom_range(0, 7))};
            cyc();
        end
        idle();

        rst_n = 0;
        #3 rst_n = 1;
        repeat (100) @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("midRstReady", 32'(ready), 32'd0);
        check("midRstOut", 32'(predTaken), 32'd0);
        #2 rst_n = 1;
        sbq.delete();
        modelReset();
        sweepCheck("resweep");
        fetch(32'h100, 2'b01, 2'b00);
        check("resweepHist", 32'(predHist[7:0]), 32'h00);
        check("resweepCtr", 32'(predCtr[1:0]), 32'd2);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
